// File: rtl/calc_sequencer.sv
// calc_sequencer: top-level calculator sequencing FSM.
// Collects operand A, operator and operand B from keypad and DIP switch,
// starts the ALU with a start/done handshake and echoes every accepted
// token to the LCD through a single-entry req/ack character port.
// Optional build macro: CALC_TIMEOUT_EN adds an ALU watchdog in S_EXEC.
module calc_sequencer #(
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic        clk_100hz,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clr,
  input  logic [7:0]  op_sw,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_err,
  output logic        lcd_req,
  output logic [7:0]  lcd_char,
  input  logic        lcd_ack,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_A       = 3'd0;
  localparam logic [2:0] S_B       = 3'd1;
  localparam logic [2:0] S_WAIT_EQ = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] SW_EQ    = 8'h01;
  localparam logic [7:0] SW_FAC   = 8'h02;

  localparam int CW = $clog2(MAX_DIGITS + 1);

  // Operator switch bit to ALU opcode.
  function automatic logic [2:0] op_code(input logic [7:0] sw);
    case (sw)
      8'h80:   return 3'd0;
      8'h40:   return 3'd1;
      8'h20:   return 3'd2;
      8'h10:   return 3'd3;
      8'h08:   return 3'd4;
      8'h04:   return 3'd5;
      8'h02:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Operator switch bit to LCD character code.
  function automatic logic [7:0] op_char(input logic [7:0] sw);
    case (sw)
      8'h80:   return 8'h2B;
      8'h40:   return 8'h2D;
      8'h20:   return 8'hD7;
      8'h10:   return 8'h2F;
      8'h08:   return 8'hF7;
      8'h04:   return 8'h5E;
      8'h02:   return 8'h21;
      default: return CH_EQ;
    endcase
  endfunction

  // Decimal shift-in; 10 bits suffice because the digit-count limit is
  // checked before a wrapped value could ever be kept.
  function automatic logic [9:0] acc10(input logic [7:0] v, input logic [3:0] d);
    return ({2'b00, v} * 10'd10) + {6'b000000, d};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [2:0]    op_q, op_d;
  logic          start_q, start_d;
  logic          lcd_req_q, lcd_req_d;
  logic [7:0]    lcd_char_q, lcd_char_d;
  logic [15:0]   result_q, result_d;
  logic [7:0]    op_prev_q, op_prev_d;
  // 'E' that could not be queued because the echo buffer was still busy.
  logic          epend_q, epend_d;

  logic          sw_evt, eq_evt, op_evt, key_evt, done_evt;
  logic [9:0]    acc_v;

`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Input event qualification: gating by busy echo buffer and one-hot check.
  always_comb begin
    sw_evt   = $onehot(op_sw) && (op_sw != op_prev_q) && !lcd_req_q;
    eq_evt   = sw_evt && (op_sw == SW_EQ);
    op_evt   = sw_evt && (op_sw != SW_EQ);
    key_evt  = key_valid && (key_digit <= 4'd9) && !lcd_req_q;
    done_evt = alu_done && (state_q == S_EXEC);
    acc_v    = acc10((state_q == S_B) ? b_q : a_q, key_digit);
  end

  // Next-state and datapath update with clr > done > digit > switch priority.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    op_d       = op_q;
    start_d    = 1'b0;
    lcd_req_d  = lcd_req_q;
    lcd_char_d = lcd_char_q;
    result_d   = result_q;
    op_prev_d  = op_sw;
    epend_d    = epend_q;
`ifdef CALC_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    if (lcd_req_q && lcd_ack) begin
      lcd_req_d = 1'b0;
    end
    if (epend_q && !lcd_req_q) begin
      lcd_req_d  = 1'b1;
      lcd_char_d = CH_E;
      epend_d    = 1'b0;
    end

    if (key_clr) begin
      state_d    = S_A;
      a_d        = 8'd0;
      b_d        = 8'd0;
      cnt_a_d    = '0;
      cnt_b_d    = '0;
      op_d       = 3'd0;
      lcd_req_d  = 1'b0;
      lcd_char_d = CH_SPACE;
      result_d   = 16'd0;
      epend_d    = 1'b0;
    end else if (done_evt) begin
      if (alu_err) begin
        state_d = S_ERR;
        if (!lcd_req_q) begin
          lcd_req_d  = 1'b1;
          lcd_char_d = CH_E;
        end else begin
          epend_d = 1'b1;
        end
      end else begin
        result_d = alu_result;
        state_d  = S_DONE;
      end
    end else begin
      case (state_q)
        S_A: begin
          if (key_evt) begin
            lcd_req_d = 1'b1;
            if ((cnt_a_q >= CW'(MAX_DIGITS)) || (acc_v > 10'd255)) begin
              state_d    = S_ERR;
              lcd_char_d = CH_E;
            end else begin
              a_d        = acc_v[7:0];
              cnt_a_d    = cnt_a_q + CW'(1);
              lcd_char_d = 8'h30 + {4'h0, key_digit};
            end
          end else if (op_evt && (cnt_a_q != '0)) begin
            op_d       = op_code(op_sw);
            lcd_req_d  = 1'b1;
            lcd_char_d = op_char(op_sw);
            state_d    = (op_sw == SW_FAC) ? S_WAIT_EQ : S_B;
          end
        end
        S_B: begin
          if (key_evt) begin
            lcd_req_d = 1'b1;
            if ((cnt_b_q >= CW'(MAX_DIGITS)) || (acc_v > 10'd255)) begin
              state_d    = S_ERR;
              lcd_char_d = CH_E;
            end else begin
              b_d        = acc_v[7:0];
              cnt_b_d    = cnt_b_q + CW'(1);
              lcd_char_d = 8'h30 + {4'h0, key_digit};
            end
          end else if (eq_evt && (cnt_b_q != '0)) begin
            lcd_req_d  = 1'b1;
            lcd_char_d = CH_EQ;
            state_d    = S_EXEC;
            start_d    = 1'b1;
          end
        end
        S_WAIT_EQ: begin
          if (eq_evt) begin
            lcd_req_d  = 1'b1;
            lcd_char_d = CH_EQ;
            b_d        = 8'd0;
            state_d    = S_EXEC;
            start_d    = 1'b1;
          end
        end
        S_EXEC: begin
`ifdef CALC_TIMEOUT_EN
          if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = S_ERR;
            if (!lcd_req_q) begin
              lcd_req_d  = 1'b1;
              lcd_char_d = CH_E;
            end else begin
              epend_d = 1'b1;
            end
          end
`endif
        end
        S_DONE: begin
          if (key_evt) begin
            state_d    = S_A;
            a_d        = {4'h0, key_digit};
            cnt_a_d    = CW'(1);
            b_d        = 8'd0;
            cnt_b_d    = '0;
            op_d       = 3'd0;
            result_d   = 16'd0;
            lcd_req_d  = 1'b1;
            lcd_char_d = 8'h30 + {4'h0, key_digit};
          end
        end
        default: begin
        end
      endcase
    end

`ifdef CALC_TIMEOUT_EN
    if (state_d != S_EXEC) begin
      tmo_d = '0;
    end else if (state_q == S_EXEC) begin
      tmo_d = tmo_q + TW'(1);
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      state_q    <= S_A;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      op_q       <= 3'd0;
      start_q    <= 1'b0;
      lcd_req_q  <= 1'b0;
      lcd_char_q <= CH_SPACE;
      result_q   <= 16'd0;
      op_prev_q  <= 8'd0;
      epend_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      op_q       <= op_d;
      start_q    <= start_d;
      lcd_req_q  <= lcd_req_d;
      lcd_char_q <= lcd_char_d;
      result_q   <= result_d;
      op_prev_q  <= op_prev_d;
      epend_q    <= epend_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  // ALU watchdog counter, cleared whenever S_EXEC is left.
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign alu_start    = start_q;
  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign lcd_req      = lcd_req_q;
  assign lcd_char     = lcd_char_q;
  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;

  logic        clk_100hz = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_clr;
  logic [7:0]  op_sw;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic        lcd_req;
  logic [7:0]  lcd_char;
  logic        lcd_ack;
  logic [15:0] result;
  logic        result_valid;
  logic        err;
  logic [2:0]  state_dbg;

  logic        auto_ack;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  lcd_log [0:63];
  int          lcd_n = 0;
  int          start_n = 0;
  int          exec_n = 0;
  logic [2:0]  cap_op;
  logic [7:0]  cap_a;
  logic [7:0]  cap_b;

  calc_sequencer dut (
    .clk_100hz   (clk_100hz),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_clr     (key_clr),
    .op_sw       (op_sw),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .alu_err     (alu_err),
    .lcd_req     (lcd_req),
    .lcd_char    (lcd_char),
    .lcd_ack     (lcd_ack),
    .result      (result),
    .result_valid(result_valid),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  always #5 clk_100hz = ~clk_100hz;

  assign lcd_ack = auto_ack & lcd_req;

  // Monitors on the inactive edge: LCD transfers, ALU starts, S_EXEC cycles.
  always @(negedge clk_100hz) begin
    if (lcd_req && lcd_ack && lcd_n < 64) begin
      lcd_log[lcd_n] = lcd_char;
      lcd_n++;
    end
    if (alu_start) begin
      start_n++;
      cap_op = alu_op;
      cap_a  = alu_a;
      cap_b  = alu_b;
    end
    if (state_dbg == 3'd3) exec_n++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100hz);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_sw(input logic [7:0] v);
    op_sw = v;
    tick();
    tick();
    tick();
  endtask

  task automatic clear();
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    tick();
  endtask

  task automatic finish_alu(input logic [15:0] r, input logic e);
    alu_result = r;
    alu_err    = e;
    alu_done   = 1'b1;
    tick();
    alu_done   = 1'b0;
    alu_err    = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] lcd_since(input int base);
    logic [63:0] p;
    p = '0;
    for (int i = base; i < lcd_n; i++) p = {p[55:0], lcd_log[i]};
    return p;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_state"},  state_dbg, 3'd0);
    check({tag, "_start"},  alu_start, 1'b0);
    check({tag, "_op"},     alu_op, 3'd0);
    check({tag, "_a"},      alu_a, 8'd0);
    check({tag, "_b"},      alu_b, 8'd0);
    check({tag, "_req"},    lcd_req, 1'b0);
    check({tag, "_char"},   lcd_char, 8'h20);
    check({tag, "_result"}, result, 16'd0);
    check({tag, "_rv"},     result_valid, 1'b0);
    check({tag, "_err"},    err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int sbase;
    int ebase;
    rst = 1'b1; key_valid = 1'b0; key_digit = 4'd0; key_clr = 1'b0;
    op_sw = 8'h00; alu_done = 1'b0; alu_result = 16'd0; alu_err = 1'b0;
    auto_ack = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check_idle("reset");

    // 12 + 3 = 15
    base = lcd_n; sbase = start_n;
    press(4'd1); press(4'd2); set_sw(8'h80); press(4'd3); set_sw(8'h01);
    check("add_state", state_dbg, 3'd3);
    check("add_starts", start_n - sbase, 1);
    check("add_op", cap_op, 3'd0);
    check("add_a", cap_a, 8'd12);
    check("add_b", cap_b, 8'd3);
    finish_alu(16'd15, 1'b0);
    check("add_result", result, 16'd15);
    check("add_rv", result_valid, 1'b1);
    check("add_done_state", state_dbg, 3'd4);
    check("add_lcd", lcd_since(base), 64'h31322B333D);
    check("add_starts_after", start_n - sbase, 1);
    // A digit in S_DONE starts a fresh A
    press(4'd4);
    check("done_key_state", state_dbg, 3'd0);
    check("done_key_a", alu_a, 8'd4);
    check("done_key_result", result, 16'd0);
    check("done_key_lcd", lcd_log[lcd_n-1], 8'h34);

    // 256 overflows operand A
    clear();
    base = lcd_n;
    press(4'd2); press(4'd5); press(4'd6);
    check("ovf_state", state_dbg, 3'd5);
    check("ovf_err", err, 1'b1);
    check("ovf_lcd", lcd_since(base), 64'h323545);
    clear();
    check_idle("clr");

    // 5 ! = with ALU error
    base = lcd_n;
    press(4'd5); set_sw(8'h02);
    check("fac_wait_state", state_dbg, 3'd2);
    set_sw(8'h01);
    check("fac_op", alu_op, 3'd6);
    check("fac_a", alu_a, 8'd5);
    check("fac_b", alu_b, 8'd0);
    finish_alu(16'd0, 1'b1);
    check("fac_err", err, 1'b1);
    check("fac_lcd", lcd_since(base), 64'h35213D45);
    clear();

    // Echo buffer full blocks further digits
    base = lcd_n;
    auto_ack = 1'b0;
    press(4'd7); press(4'd8);
    check("hold_a", alu_a, 8'd7);
    check("hold_req", lcd_req, 1'b1);
    check("hold_char", lcd_char, 8'h37);
    auto_ack = 1'b1;
    tick();
    check("hold_req_drop", lcd_req, 1'b0);
    set_sw(8'hC0);
    check("multihot_state", state_dbg, 3'd0);
    check("multihot_lcd_n", lcd_n - base, 1);
    set_sw(8'h40); press(4'd2); set_sw(8'h01);
    check("sub_state", state_dbg, 3'd3);
    check("sub_a", alu_a, 8'd7);
    check("sub_b", alu_b, 8'd2);
    check("sub_op", alu_op, 3'd1);
    check("sub_lcd", lcd_since(base), 64'h372D323D);

    // key_clr beats alu_done in the same cycle
    key_clr = 1'b1; alu_done = 1'b1; alu_result = 16'd99;
    tick();
    key_clr = 1'b0; alu_done = 1'b0;
    tick();
    check("clrdone_state", state_dbg, 3'd0);
    check("clrdone_result", result, 16'd0);
    check("clrdone_rv", result_valid, 1'b0);
    finish_alu(16'd77, 1'b0);
    check("late_done_state", state_dbg, 3'd0);
    check("late_done_result", result, 16'd0);

    // S_EXEC without alu_done
    press(4'd1); set_sw(8'h80); press(4'd1);
    ebase = exec_n;
    set_sw(8'h01);
    for (int i = 0; i < 300 && state_dbg == 3'd3; i++) tick();
`ifdef CALC_TIMEOUT_EN
    check("tmo_state", state_dbg, 3'd5);
    check("tmo_cycles", exec_n - ebase, 200);
    tick();
    check("tmo_lcd", lcd_log[lcd_n-1], 8'h45);
`else
    check("wait_state", state_dbg, 3'd3);
    check("wait_err", err, 1'b0);
`endif
    clear();
    check("final_state", state_dbg, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
